// File: rtl/loader_pkg.sv
// Shared types for the program/data loader: command and state encodings,
// header field positions, and the skip-length helper.
// Purely declarative; no latency or flow-control behaviour of its own.
package loader_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_I  = 2'b00,
    CMD_LOAD_D  = 2'b01,
    CMD_RUN_SET = 2'b10,
    CMD_RUN_CLR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ILO  = 3'd1,
    ST_IHI  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_SKIP = 3'd5
  } state_e;

  // Header word layout
  localparam int HDR_CMD_HI  = 15;
  localparam int HDR_CMD_LO  = 14;
  localparam int HDR_ADDR_HI = 12;
  localparam int HDR_ADDR_LO = 8;
  localparam int HDR_CNT_HI  = 4;
  localparam int HDR_CNT_LO  = 0;

  // Enough for 32 instructions * 2 words + trailer
  localparam int SKIP_W = 7;

  // Words following a rejected load header, minus one, so SKIP can count down to zero.
  function automatic logic [SKIP_W-1:0] skip_len_m1(input cmd_e cmd, input logic [4:0] cnt_m1,
                                                    input logic trailer);
    logic [SKIP_W-1:0] n;
    n = (cmd == CMD_LOAD_I) ? {1'b0, cnt_m1, 1'b1} : {2'b00, cnt_m1};
    return n + SKIP_W'(trailer);
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Running mod-2^W sum of a packet: reloads with the header, adds each later word.
// Sum is registered; match_o compares it combinationally with the current word.
// No flow control of its own; follows the loader's accept strobes.
module loader_csum #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] word_i,
  output logic         match_o
);

  logic [W-1:0] sum_q, sum_d;

  // Next sum: a header restarts the sum, every other accepted word accumulates.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = word_i;
    end else if (add_i) begin
      sum_d = sum_q + word_i;
    end
  end

  // Sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_o = (sum_q == word_i);

endmodule

// File: rtl/prog_loader.sv
// Packet loader: turns a 16-bit word stream into imem/dmem write strobes and a run enable.
// Latency: write strobe/addr/data registered on the accepting edge, valid for the next cycle.
// Backpressure: none; in_ready is high in every state out of reset. Macro: LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int NUM_SIZE         = 16,
  parameter int NUM_INSTRUCTIONS = 16,
  parameter int WORDS_IN_MEMORY  = 32,
  localparam int IADDR_W         = $clog2(NUM_INSTRUCTIONS),
  localparam int DADDR_W         = $clog2(WORDS_IN_MEMORY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SIZE-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [IADDR_W-1:0]    imem_addr,
  output logic [2*NUM_SIZE-1:0] imem_wdata,
  output logic                  dmem_we,
  output logic [DADDR_W-1:0]    dmem_addr,
  output logic [NUM_SIZE-1:0]   dmem_wdata,
  output logic                  accel_run,
  output logic                  busy,
  output logic                  err
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e END_ST  = ST_CSUM;
  localparam logic   TRAILER = 1'b1;
`else
  localparam state_e END_ST  = ST_IDLE;
  localparam logic   TRAILER = 1'b0;
`endif

  localparam logic [IADDR_W-1:0] IADDR_ONE = 1;
  localparam logic [DADDR_W-1:0] DADDR_ONE = 1;

  state_e                  state_q, state_d;
  logic                    ready_q;
  logic [IADDR_W-1:0]      iaddr_q, iaddr_d;
  logic [DADDR_W-1:0]      daddr_q, daddr_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [NUM_SIZE-1:0]     lo_q, lo_d;
  logic [SKIP_W-1:0]       skip_q, skip_d;
  logic                    run_q, run_d;
  logic                    err_q, err_d;
  logic                    imem_we_q, imem_we_d;
  logic [IADDR_W-1:0]      imem_addr_q, imem_addr_d;
  logic [2*NUM_SIZE-1:0]   imem_wdata_q, imem_wdata_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [DADDR_W-1:0]      dmem_addr_q, dmem_addr_d;
  logic [NUM_SIZE-1:0]     dmem_wdata_q, dmem_wdata_d;

  logic       in_fire;
  cmd_e       hdr_cmd;
  logic [4:0] hdr_addr;
  logic [4:0] hdr_cnt;
  logic       last_elem;
  logic       unused_hdr_bits;

  assign in_fire   = in_valid && ready_q;
  assign hdr_cmd   = cmd_e'(in_data[HDR_CMD_HI:HDR_CMD_LO]);
  assign hdr_addr  = in_data[HDR_ADDR_HI:HDR_ADDR_LO];
  assign hdr_cnt   = in_data[HDR_CNT_HI:HDR_CNT_LO];
  assign last_elem = (cnt_q == 5'd0);
  // Reserved header bits carry no meaning
  assign unused_hdr_bits = ^{in_data[13], in_data[7:5]};

`ifdef LOADER_CHECKSUM_EN
  logic csum_match;

  loader_csum #(.W(NUM_SIZE)) u_csum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (in_fire && (state_q == ST_IDLE)),
    .add_i   (in_fire && (state_q != ST_IDLE)),
    .word_i  (in_data),
    .match_o (csum_match)
  );
`endif

  // Next-state and output decode; strobes default low so they last one cycle.
  always_comb begin
    state_d      = state_q;
    iaddr_d      = iaddr_q;
    daddr_d      = daddr_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    skip_d       = skip_q;
    run_d        = run_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    if (in_fire) begin
      case (state_q)
        ST_IDLE: begin
          case (hdr_cmd)
            CMD_LOAD_I, CMD_LOAD_D: begin
              cnt_d   = hdr_cnt;
              iaddr_d = IADDR_W'(hdr_addr);
              daddr_d = DADDR_W'(hdr_addr);
              if (run_q) begin
                // Loading under a running core would corrupt it: drain the packet
                err_d   = 1'b1;
                skip_d  = skip_len_m1(hdr_cmd, hdr_cnt, TRAILER);
                state_d = ST_SKIP;
              end else begin
                state_d = (hdr_cmd == CMD_LOAD_I) ? ST_ILO : ST_DATA;
              end
            end
            CMD_RUN_SET: begin
              if (!err_q) run_d = 1'b1;
            end
            default: begin
              run_d = 1'b0;
            end
          endcase
        end
        ST_ILO: begin
          lo_d    = in_data;
          state_d = ST_IHI;
        end
        ST_IHI: begin
          imem_we_d    = 1'b1;
          imem_addr_d  = iaddr_q;
          imem_wdata_d = {in_data, lo_q};
          iaddr_d      = iaddr_q + IADDR_ONE;
          cnt_d        = cnt_q - 5'd1;
          state_d      = last_elem ? END_ST : ST_ILO;
        end
        ST_DATA: begin
          dmem_we_d    = 1'b1;
          dmem_addr_d  = daddr_q;
          dmem_wdata_d = in_data;
          daddr_d      = daddr_q + DADDR_ONE;
          cnt_d        = cnt_q - 5'd1;
          state_d      = last_elem ? END_ST : ST_DATA;
        end
        ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (!csum_match) err_d = 1'b1;
`endif
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == '0) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; ready comes up on the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      iaddr_q      <= '0;
      daddr_q      <= '0;
      cnt_q        <= '0;
      lo_q         <= '0;
      skip_q       <= '0;
      run_q        <= 1'b0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= 1'b1;
      iaddr_q      <= iaddr_d;
      daddr_q      <= daddr_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      skip_q       <= skip_d;
      run_q        <= run_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign accel_run  = run_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed packets, packet-level model of writes/run/err/busy,
// per-cycle compare on the falling edge, plus literal pins on the captured memories.
module tb_prog_loader;

  localparam int NI = 16;
  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, imem_we, dmem_we, accel_run, busy, err;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [4:0]  dmem_addr;
  logic [15:0] dmem_wdata;

  prog_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .accel_run(accel_run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_i;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         expq[$];
  logic [15:0] pay[$];
  bit          run_m, err_m, busy_m, rdy_m, chk_en;
  logic [31:0] ish [NI];
  logic [15:0] dsh [NW];
  int          icnt = 0;
  int          dcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_write(input bit is_i, input int addr, input logic [31:0] data);
    wr_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_write actual=%s a=%0d d=%h cyc=%0d required=none",
               is_i ? "imem" : "dmem", addr, data, cyc);
    end else begin
      e = expq[0];
      expq.delete(0);
      if (e.is_i != is_i || e.addr != addr || e.data !== data || e.cyc != cyc) begin
        errors++;
        $display("FAIL write actual=%s a=%0d d=%h cyc=%0d required=%s a=%0d d=%h cyc=%0d",
                 is_i ? "imem" : "dmem", addr, data, cyc,
                 e.is_i ? "imem" : "dmem", e.addr, e.data, e.cyc);
      end
    end
  endtask

  // Per-cycle compare of strobes and levels against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL write_missing actual=none required=%s a=%0d d=%h cyc=%0d",
                 expq[0].is_i ? "imem" : "dmem", expq[0].addr, expq[0].data, expq[0].cyc);
        expq.delete(0);
      end
      if (imem_we === 1'b1) begin
        icnt++;
        ish[imem_addr] = imem_wdata;
        cmp_write(1'b1, int'(imem_addr), imem_wdata);
      end
      if (dmem_we === 1'b1) begin
        dcnt++;
        dsh[dmem_addr] = dmem_wdata;
        cmp_write(1'b0, int'(dmem_addr), {16'h0, dmem_wdata});
      end
      chk("accel_run", {31'd0, accel_run}, {31'd0, run_m});
      chk("err", {31'd0, err}, {31'd0, err_m});
      chk("busy", {31'd0, busy}, {31'd0, busy_m});
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_m});
    end
  end

  task automatic put(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one packet (payload from pay) and updates the model at packet level.
  task automatic send_pkt(input logic [15:0] hdr, input int gap_at, input int stop_at, input bit bad);
    logic [1:0]  cmd;
    int          start, cnt, nw, c;
    bit          skip;
    logic [15:0] sum;
    cmd   = hdr[15:14];
    start = int'(hdr[12:8]);
    cnt   = int'(hdr[4:0]) + 1;
    put(hdr);
    if (cmd == 2'b10) begin
      if (!err_m) run_m = 1'b1;
      return;
    end
    if (cmd == 2'b11) begin
      run_m = 1'b0;
      return;
    end
    skip = run_m;
    if (skip) err_m = 1'b1;
    busy_m = 1'b1;
    nw  = (cmd == 2'b00) ? 2 * cnt : cnt;
    sum = hdr;
    for (int i = 0; i < nw; i++) begin
      c = cyc;
      put(pay[i]);
      sum = sum + pay[i];
      if (!skip) begin
        if (cmd == 2'b01)
          expq.push_back('{is_i: 1'b0, addr: (start + i) % NW, data: {16'h0, pay[i]}, cyc: c + 1});
        else if (i % 2 == 1)
          expq.push_back('{is_i: 1'b1, addr: (start + i / 2) % NI, data: {pay[i], pay[i-1]}, cyc: c + 1});
      end
      if (i + 1 == stop_at) begin
        idle(1);
        return;
      end
      if (i == gap_at) idle(5);
    end
`ifdef LOADER_CHECKSUM_EN
    put(bad ? sum + 16'd1 : sum);
    if (bad) err_m = 1'b1;
`endif
    busy_m = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    run_m    = 1'b0;
    err_m    = 1'b0;
    busy_m   = 1'b0;
    rdy_m    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_imem_addr", {28'd0, imem_addr}, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_dmem_addr", {27'd0, dmem_addr}, 32'd0);
    chk("rst_dmem_wdata", {16'd0, dmem_wdata}, 32'd0);
    rst = 1'b0;
    chk("ready_after_release", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rdy_m = 1'b1;
    chk("ready_first_edge", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int d0, i0;
    chk_en = 1'b0;
    #2;
    chk_en = 1'b1;
    do_reset();

    // LOAD_D addr 8, four words
    pay = '{16'd1, 16'd2, 16'd3, 16'd4};
    d0 = dcnt;
    send_pkt(16'h4803, -1, 99, 1'b0);
    idle(2);
    chk("ld_d_count", dcnt - d0, 32'd4);
    chk("ld_d_m8", {16'd0, dsh[8]}, 32'd1);
    chk("ld_d_m9", {16'd0, dsh[9]}, 32'd2);
    chk("ld_d_m11", {16'd0, dsh[11]}, 32'd4);

    // LOAD_I addr 0, two instructions
    pay = '{16'hAAAA, 16'h0004, 16'h0000, 16'h0028};
    i0 = icnt;
    send_pkt(16'h0001, -1, 99, 1'b0);
    idle(2);
    chk("ld_i_count", icnt - i0, 32'd2);
    chk("ld_i_m0", ish[0], 32'h0004AAAA);
    chk("ld_i_m1", ish[1], 32'h00280000);

    // Back-to-back: dmem wrap from 30, then imem wrap from 15
    pay = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    send_pkt(16'h5E03, -1, 99, 1'b0);
    pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_pkt(16'h0F01, -1, 99, 1'b0);
    idle(2);
    chk("wrap_d30", {16'd0, dsh[30]}, 32'h11);
    chk("wrap_d31", {16'd0, dsh[31]}, 32'h22);
    chk("wrap_d0", {16'd0, dsh[0]}, 32'h33);
    chk("wrap_d1", {16'd0, dsh[1]}, 32'h44);
    chk("wrap_i15", ish[15], 32'h22221111);
    chk("wrap_i0", ish[0], 32'h44443333);

    // Stall mid-packet, reserved header bits set (addr 4, count 2)
    pay = '{16'h0A5A, 16'h0B5B};
    send_pkt(16'h64E1, 0, 99, 1'b0);
    idle(2);
    chk("gap_d4", {16'd0, dsh[4]}, 32'h0A5A);
    chk("gap_d5", {16'd0, dsh[5]}, 32'h0B5B);

    // Reset mid-packet, then a fresh header
    pay = '{16'h0077, 16'h0078, 16'h0079, 16'h007A};
    send_pkt(16'h4203, -1, 1, 1'b0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_d2", {16'd0, dsh[2]}, 32'h0077);
    do_reset();
    pay = '{16'h000A, 16'h000B};
    send_pkt(16'h4101, -1, 99, 1'b0);
    idle(2);
    chk("fresh_d1", {16'd0, dsh[1]}, 32'h000A);
    chk("fresh_d2", {16'd0, dsh[2]}, 32'h000B);

    // Load while running
    send_pkt(16'h8000, -1, 99, 1'b0);
    chk("run_set", {31'd0, accel_run}, 32'd1);
    pay = '{16'h1234};
    d0 = dcnt;
    send_pkt(16'h4000, -1, 99, 1'b0);
    idle(2);
    chk("lwr_err", {31'd0, err}, 32'd1);
    chk("lwr_run", {31'd0, accel_run}, 32'd1);
    chk("lwr_no_write", dcnt - d0, 32'd0);
    chk("lwr_d0_kept", {16'd0, dsh[0]}, 32'h0033);
    send_pkt(16'hC000, -1, 99, 1'b0);
    chk("run_clr", {31'd0, accel_run}, 32'd0);
    send_pkt(16'h8000, -1, 99, 1'b0);
    chk("run_set_blocked", {31'd0, accel_run}, 32'd0);
    idle(2);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    pay = '{16'h0005};
    send_pkt(16'h4000, -1, 99, 1'b0);
    idle(2);
    chk("csum_ok_err", {31'd0, err}, 32'd0);
    chk("csum_ok_d0", {16'd0, dsh[0]}, 32'h0005);
    send_pkt(16'h4000, -1, 99, 1'b1);
    chk("csum_bad_err", {31'd0, err}, 32'd1);
    send_pkt(16'h8000, -1, 99, 1'b0);
    chk("csum_bad_run", {31'd0, accel_run}, 32'd0);
    idle(2);
`endif

    idle(3);
    chk("pending_writes", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
